// File: rtl/latch_bus_sched.sv
// Round-robin sequencer for the shared latch bus: grants one latch, reads it, captures the address, optional +/-1 write-back.
// Read-only 2 cycles, inc/dec 3 cycles (IDLE -> READ -> [WRITE] -> IDLE); requests are only sampled in IDLE.
module latch_bus_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
) (
    input  logic                   clk50M_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [2*NUM_REQ-1:0]   op_i,
    input  logic [DATA_W-1:0]      bus_i,
    output logic [NUM_REQ-1:0]     latch_rd_o,
    output logic [NUM_REQ-1:0]     latch_wr_o,
    output logic [DATA_W-1:0]      wb_data_o,
    output logic [DATA_W-1:0]      addr_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic                   busy_o
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SEL_W:0] NUM_REQ_W = (SEL_W+1)'(NUM_REQ);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  addr_q, addr_d;

    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   cand;
    logic [1:0]         grant_op;
    logic [NUM_REQ-1:0] sel_oh;

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a,
                                                  input logic [SEL_W-1:0] b);
        logic [SEL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NUM_REQ_W) begin
            s = s - NUM_REQ_W;
        end
        return s[SEL_W-1:0];
    endfunction

    // First set request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(rr_ptr_q, SEL_W'(i));
            if (!grant_vld && req_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant_op = op_i[{grant_idx, 1'b0} +: 2];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        op_d     = op_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    sel_d    = grant_idx;
                    op_d     = (grant_op == OP_RSV) ? OP_RD : grant_op;
                    rr_ptr_d = wrap_add(grant_idx, SEL_W'(1));
                    state_d  = READ;
                end
            end
            READ: begin
                addr_d  = bus_i;
                state_d = (op_q == OP_RD) ? IDLE : WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only, so no req/op path reaches the latches.
    always_comb begin
        sel_oh     = NUM_REQ'(1) << sel_q;
        latch_rd_o = '0;
        latch_wr_o = '0;
        done_o     = '0;
        wb_data_o  = '0;
        busy_o     = (state_q != IDLE);
        addr_o     = addr_q;
        case (state_q)
            READ: begin
                latch_rd_o = sel_oh;
                if (op_q == OP_RD) begin
                    done_o = sel_oh;
                end
            end
            WRITE: begin
                latch_wr_o = sel_oh;
                done_o     = sel_oh;
                if (op_q == OP_INC) begin
                    wb_data_o = addr_q + DATA_W'(1);
                end else if (op_q == OP_DEC) begin
                    wb_data_o = addr_q - DATA_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk50M_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            op_q     <= OP_RD;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
        end
    end

endmodule
